upsampler_nx: RTL and testbench

Parametrised nearest-neighbour image upsampler that replicates every input pixel SCALE times horizontally and every input line SCALE times vertically, using an internal one-line buffer. It sits between a downsampled-frame source (FIFO or processing stage) and the full-resolution video path. Both input and output use valid/ready handshakes. It replaces the fixed 4x, 800x600, FIFO-read-strobe upsampler.

---
 rtl/upsampler_nx.sv | 247 ++++++++++++++++++++++++
 tb/tb_upsampler_nx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsampler_nx.sv
// upsampler_nx - nearest-neighbour image upsampler.
//
// Every input pixel is replicated SCALE = 1<<SCALE_LOG2 times horizontally
// and every input line SCALE times vertically. The first copy of a line
// (LIVE) is produced straight from the input stream and captured in a one-line
// buffer; the remaining SCALE-1 copies (REPLAY) are read back from that buffer
// while the input is stalled.
//
// Optional feature macro: UPSAMPLER_SOF_RESYNC_EN
//   Adds in_sof / sof_err. An in_sof beat accepted anywhere other than the
//   first pixel of a frame aborts the frame and restarts it at row 0, col 0;
//   sof_err then stays set until reset.
//
// Handshakes: a beat moves on a port in a cycle where valid && ready are both
// high at the rising clock edge. valid never waits for ready. Once out_valid
// is high, out_* hold their values until out_ready is seen high.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   in_valid/in_ready     input pixel handshake, in_data pixel value
//   in_sof                first pixel of frame (resync build only)
//   out_valid/out_ready   output pixel handshake, out_data pixel value
//   out_sof               beat is output row 0, col 0
//   out_eol               beat is the last column of an output row
//   out_row, out_col      output coordinates of the current beat
//   frame_done            one-cycle pulse when the last beat of a frame is taken
//   sof_err               sticky resync flag (resync build only)
//
// IN_COLS and IN_ROWS must be at least 2.

module upsampler_nx #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_COLS    = 200,
    parameter int IN_ROWS    = 150,
    parameter int SCALE_LOG2 = 2,
    localparam int SCALE     = 1 << SCALE_LOG2,
    localparam int CW        = $clog2(IN_COLS * SCALE),
    localparam int RW        = $clog2(IN_ROWS * SCALE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef UPSAMPLER_SOF_RESYNC_EN
    input  logic                  in_sof,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  frame_done
`ifdef UPSAMPLER_SOF_RESYNC_EN
    ,
    output logic                  sof_err
`endif
);

    localparam int COLW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int ROWW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int SW   = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [COLW-1:0] COL_MAX = COLW'(IN_COLS - 1);
    localparam logic [ROWW-1:0] ROW_MAX = ROWW'(IN_ROWS - 1);
    localparam logic [SW-1:0]   SMAX    = SW'(SCALE - 1);

    typedef enum logic [1:0] {
        LIVE     = 2'd0,
        PREFETCH = 2'd1,
        REPLAY   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Counters name the beat that will be generated next.
    logic [COLW-1:0] in_col, in_col_nxt;
    logic [ROWW-1:0] in_row, in_row_nxt;
    logic [SW-1:0]   hrep, hrep_nxt;
    logic [SW-1:0]   vrep, vrep_nxt;

    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] line_buf [IN_COLS];
    logic [COLW-1:0]       rd_addr;

    logic                  ld;
    logic                  emit;
    logic                  wr_en;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [COLW-1:0]       cur_col;
    logic [ROWW-1:0]       cur_row;
    logic                  beat_sof;
    logic                  beat_eol;
    logic                  beat_last;
`ifdef UPSAMPLER_SOF_RESYNC_EN
    logic                  resync;
`endif

    // The output register may take a new beat when it is empty or drained.
    assign ld = !out_valid || out_ready;

    // Read address runs one step ahead: it follows the column the next beat
    // will use, so rd_data already holds line_buf[in_col] when REPLAY emits.
    assign rd_addr = in_col_nxt;

    assign frame_done = out_valid && out_ready && out_last;

    always_comb begin
        state_nxt  = state;
        in_col_nxt = in_col;
        in_row_nxt = in_row;
        hrep_nxt   = hrep;
        vrep_nxt   = vrep;
        in_ready   = 1'b0;
        emit       = 1'b0;
        wr_en      = 1'b0;
        beat_data  = hold_q;
        cur_col    = in_col;
        cur_row    = in_row;
`ifdef UPSAMPLER_SOF_RESYNC_EN
        resync     = 1'b0;
`endif

        case (state)
            LIVE: begin
                if (hrep == '0) begin
                    in_ready = ld && !reset;
                    if (in_ready && in_valid) begin
                        emit      = 1'b1;
                        beat_data = in_data;
                        wr_en     = (SCALE_LOG2 != 0);
`ifdef UPSAMPLER_SOF_RESYNC_EN
                        // Misplaced start of frame: restart the grid here.
                        if (in_sof && (in_row != '0 || in_col != '0)) begin
                            resync  = 1'b1;
                            cur_col = '0;
                            cur_row = '0;
                        end
`endif
                    end
                end else if (ld) begin
                    emit = 1'b1;
                end
            end
            PREFETCH: begin
                if (ld) begin
                    state_nxt = REPLAY;
                end
            end
            REPLAY: begin
                if (ld) begin
                    emit      = 1'b1;
                    beat_data = rd_data;
                end
            end
            default: state_nxt = LIVE;
        endcase

        if (emit) begin
            in_col_nxt = cur_col;
            in_row_nxt = cur_row;
            if (hrep != SMAX) begin
                hrep_nxt = hrep + 1'b1;
            end else begin
                hrep_nxt = '0;
                if (cur_col != COL_MAX) begin
                    in_col_nxt = cur_col + 1'b1;
                end else begin
                    in_col_nxt = '0;
                    if (vrep != SMAX) begin
                        vrep_nxt  = vrep + 1'b1;
                        state_nxt = PREFETCH;
                    end else begin
                        vrep_nxt   = '0;
                        state_nxt  = LIVE;
                        in_row_nxt = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
                    end
                end
            end
        end

        beat_sof  = (cur_row == '0) && (cur_col == '0) && (vrep == '0) && (hrep == '0);
        beat_eol  = (cur_col == COL_MAX) && (hrep == SMAX);
        beat_last = beat_eol && (cur_row == ROW_MAX) && (vrep == SMAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= LIVE;
            in_col    <= '0;
            in_row    <= '0;
            hrep      <= '0;
            vrep      <= '0;
            hold_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_col <= in_col_nxt;
            in_row <= in_row_nxt;
            hrep   <= hrep_nxt;
            vrep   <= vrep_nxt;
            if (in_ready && in_valid) begin
                hold_q <= in_data;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= beat_data;
                out_sof   <= beat_sof;
                out_eol   <= beat_eol;
                out_row   <= (RW'(cur_row) << SCALE_LOG2) + RW'(vrep);
                out_col   <= (CW'(cur_col) << SCALE_LOG2) + CW'(hrep);
                out_last  <= beat_last;
            end else if (ld) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef UPSAMPLER_SOF_RESYNC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sof_err <= 1'b0;
        end else if (emit && resync) begin
            sof_err <= 1'b1;
        end
    end
`endif

    // Line buffer: not reset, written only by LIVE accepts, synchronous read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            line_buf[cur_col] <= in_data;
        end
        rd_data <= line_buf[rd_addr];
    end

endmodule

// File: tb/tb_upsampler_nx.sv
// Bench for upsampler_nx: 4x3 input frame at 2x.
// Inputs change 1-2 time units after the rising edge; outputs are sampled on
// the falling edge. A stream-level reference model pushes expected output
// beats into exp_q as input pixels are accepted; the monitor pops and compares.

module tb_upsampler_nx;

  localparam int DW    = 8;
  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int SL    = 1;
  localparam int S     = 1 << SL;
  localparam int N_OC  = COLS * S;
  localparam int N_OR  = ROWS * S;
  localparam int CW    = $clog2(N_OC);
  localparam int RW    = $clog2(N_OR);
  localparam int W     = DW + 3 + RW + CW;
  localparam int FRAME_CYCLES = N_OC * N_OR - 1 + ROWS * (S - 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;
`ifdef UPSAMPLER_SOF_RESYNC_EN
  logic          in_sof = 1'b0;
  logic          sof_err;
`endif

  upsampler_nx #(
    .DATA_WIDTH(DW),
    .IN_COLS(COLS),
    .IN_ROWS(ROWS),
    .SCALE_LOG2(SL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef UPSAMPLER_SOF_RESYNC_EN
    .in_sof(in_sof),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_row(out_row),
    .out_col(out_col),
    .frame_done(frame_done)
`ifdef UPSAMPLER_SOF_RESYNC_EN
    ,
    .sof_err(sof_err)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail = 0;
  int fd_count = 0;
  int last_fd_cyc = 0;
  int exp_fd = 0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_col = 0;
  int m_row = 0;
  logic [DW-1:0] m_line[COLS];

  function automatic logic [W-1:0] mk(input logic [DW-1:0] d, input int orow, input int ocol);
    logic sof, eol, last;
    sof  = (orow == 0) && (ocol == 0);
    eol  = (ocol == N_OC - 1);
    last = eol && (orow == N_OR - 1);
    return {d, sof, eol, last, RW'(orow), CW'(ocol)};
  endfunction

  // Output image pixel (r, c) is input pixel (r / S, c / S); each accepted
  // pixel yields its S copies on the first copy of the line, and the last
  // pixel of a line also releases the S-1 repeated lines.
  task automatic model_accept(input logic [DW-1:0] d);
`ifdef UPSAMPLER_SOF_RESYNC_EN
    if (in_sof && (m_row != 0 || m_col != 0)) begin
      m_row = 0;
      m_col = 0;
    end
`endif
    m_line[m_col] = d;
    for (int h = 0; h < S; h++) exp_q.push_back(mk(d, m_row * S, m_col * S + h));
    if (m_col == COLS - 1) begin
      for (int v = 1; v < S; v++)
        for (int c = 0; c < COLS; c++)
          for (int h = 0; h < S; h++)
            exp_q.push_back(mk(m_line[c], m_row * S + v, c * S + h));
      m_col = 0;
      if (m_row == ROWS - 1) begin
        m_row = 0;
        exp_fd++;
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
  endtask

  // ---------------- out_ready driver ----------------
  int or_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
  int pat_idx = 0;
  always @(posedge clock) begin
    #1;
    case (or_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        out_ready = (pat_idx == 0) || (pat_idx == 3);
        pat_idx = (pat_idx + 1) % 4;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- input driver tasks (called at posedge+2) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send_pixel(input logic [DW-1:0] d);
    int budget;
    logic ok;
    budget = 200;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    while (budget > 0) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        model_accept(d);
        @(posedge clock);
        #2;
        break;
      end
      @(posedge clock);
      #2;
      budget--;
    end
    in_valid = 1'b0;
    check("accept_in_time", ok, 1);
  endtask

  task automatic send_random(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_pixel(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic wait_fd(input int target, input string name);
    int budget;
    budget = 3000;
    while (fd_count < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check(name, fd_count >= target, 1);
    @(posedge clock);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (!reset) begin
      if (frame_done) begin
        fd_count++;
        last_fd_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        act = {out_data, out_sof, out_eol, frame_done, out_row, out_col};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("beat", act, exp);
        end
      end else if (frame_done) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_done_without_beat: got 1 expected 0");
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int budget;
    logic found;

    // Reset state, with in_valid high to show in_ready is held low.
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_sof, out_eol, frame_done}, 0);
    check("rst_row_col", {out_row, out_col}, 0);
`ifdef UPSAMPLER_SOF_RESYNC_EN
    check("rst_sof_err", sof_err, 0);
`endif
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #2;

    // Frame 1: pixels 1..12, always ready, no gaps; latency and frame length.
    or_mode = 0;
    send_pixel(8'd1);
    t0 = cyc;
    #1;
    check("first_latency_valid", out_valid, 1);
    check("first_latency_data", out_data, 1);
    check("first_sof", {out_sof, out_row, out_col}, {1'b1, RW'(0), CW'(0)});
    for (int i = 2; i <= COLS * ROWS; i++) send_pixel(8'(i));
    wait_fd(1, "frame1_done");
    check("frame1_cycles", last_fd_cyc - t0, FRAME_CYCLES);

    // Frame 2: random gaps and random back-pressure.
    or_mode = 1;
    send_random(COLS * ROWS, 2);
    wait_fd(2, "frame2_done");

    // Frames 3 and 4 back to back under the 1,0,0,1 ready pattern.
    or_mode = 2;
    pat_idx = 0;
    send_random(2 * COLS * ROWS, 0);
    wait_fd(4, "frame34_done");

    // Mid-frame reset during the repeated copy of line 0 (output row 1).
    or_mode = 0;
    send_random(COLS, 0);
    found = 1'b0;
    budget = 200;
    while (!found && budget > 0) begin
      @(negedge clock);
      if (out_valid && out_row == RW'(1)) found = 1'b1;
      budget--;
    end
    check("reached_replay_row1", found, 1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_flags", {out_sof, out_eol, frame_done}, 0);
    check("midrst_row_col", {out_row, out_col}, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(posedge clock);
    #2;
    check("midrst_in_ready_held", in_ready, 0);
    reset = 1'b0;
    send_pixel(8'hA5);
    #1;
    check("after_rst_first", {out_valid, out_sof, out_row, out_col, out_data},
          {1'b1, 1'b1, RW'(0), CW'(0), 8'hA5});
    send_random(COLS * ROWS - 1, 0);
    wait_fd(5, "after_rst_done");

`ifdef UPSAMPLER_SOF_RESYNC_EN
    // Resync: normal in_sof on pixel 0, misplaced in_sof on input pixel 5.
    check("sof_err_cleared", sof_err, 0);
    in_sof = 1'b1;
    send_pixel(8'h11);
    in_sof = 1'b0;
    send_random(4, 0);
    check("sof_err_normal_sof", sof_err, 0);
    in_sof = 1'b1;
    send_pixel(8'h5A);
    in_sof = 1'b0;
    #1;
    check("resync_beat", {out_valid, out_sof, out_row, out_col, out_data},
          {1'b1, 1'b1, RW'(0), CW'(0), 8'h5A});
    check("sof_err_set", sof_err, 1);
    send_random(COLS * ROWS - 1, 0);
    wait_fd(6, "resync_frame_done");
    check("sof_err_sticky", sof_err, 1);
`endif

    idle(20);
    check("queue_empty", exp_q.size(), 0);
    check("frame_done_count", fd_count, exp_fd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
